// File: rtl/brisc_pkg.sv
// brisc_pkg: shared types for the brisc 5-stage pipeline (F, D, A, C, WB).
//   REG_BITS              register index width
//   fwd_src_e             A-stage operand source (NONE / FROM_C / FROM_WB)
//   pc_src_e              next-PC source (FROM_A = taken redirect from A)
//   result_src_e          result mux select (FROM_CACHE = load)
//   MAX_INFLIGHT_DEFAULT  default cap on outstanding long-latency ops
//   inflight_t            inflight counter type for the default cap
package brisc_pkg;

  localparam int REG_BITS = 5;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    FROM_C  = 2'd1,
    FROM_WB = 2'd2
  } fwd_src_e;

  typedef enum logic [0:0] {
    FROM_PC4 = 1'b0,
    FROM_A   = 1'b1
  } pc_src_e;

  typedef enum logic [1:0] {
    FROM_ALU   = 2'd0,
    FROM_CACHE = 2'd1,
    FROM_PC    = 2'd2
  } result_src_e;

  localparam int MAX_INFLIGHT_DEFAULT = 4;
  localparam int INFLIGHT_W = $clog2(MAX_INFLIGHT_DEFAULT + 1);
  typedef logic [INFLIGHT_W-1:0] inflight_t;

  // The youngest producer wins: C is checked before WB. x0 never forwards.
  function automatic fwd_src_e fwd_select(
    input logic [REG_BITS-1:0] rs,
    input logic [REG_BITS-1:0] rd_c,
    input logic                write_c,
    input logic [REG_BITS-1:0] rd_wb,
    input logic                write_wb
  );
    if (rs != '0 && rs == rd_c && write_c)        return FROM_C;
    else if (rs != '0 && rs == rd_wb && write_wb) return FROM_WB;
    else                                          return NONE;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pending bit per architectural register for results still
// owed by the MUL unit, plus a count of outstanding long-latency ops.
//   clk, rst_n          clock, asynchronous active-low reset
//   issue, issue_rd     a long-latency op leaves D this cycle writing issue_rd
//   mul_done, mul_done_rd  MUL unit writes back mul_done_rd this cycle
//   rs1, rs2, rd        D-stage lookup indices
//   pend_rs1/rs2/rd     effective pending bits (same-cycle writeback removed)
//   full                counter has reached MAX_INFLIGHT
//   inflight            outstanding long-latency op count
module hazard_scoreboard
  import brisc_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
  parameter int NUM_REGS     = 2**REG_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              issue,
  input  logic [REG_BITS-1:0]               issue_rd,
  input  logic                              mul_done,
  input  logic [REG_BITS-1:0]               mul_done_rd,
  input  logic [REG_BITS-1:0]               rs1,
  input  logic [REG_BITS-1:0]               rs2,
  input  logic [REG_BITS-1:0]               rd,
  output logic                              pend_rs1,
  output logic                              pend_rs2,
  output logic                              pend_rd,
  output logic                              full,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
);

  localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [NUM_REGS-1:0] done_mask, set_mask, pend_eff;
  logic [CNT_W-1:0]    inflight_q, inflight_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    done_mask = '0;
    set_mask  = '0;
    if (mul_done) done_mask[mul_done_rd] = 1'b1;
    if (issue)    set_mask[issue_rd]     = 1'b1;
  end

  // The register file is write-through, so a writeback in this very cycle
  // already resolves the hazard.
  assign pend_eff  = pending_q & ~done_mask;
  assign pend_rs1  = pend_eff[rs1];
  assign pend_rs2  = pend_eff[rs2];
  assign pend_rd   = pend_eff[rd];

  // Clear first, then set: a reissue to the register being written back
  // keeps it pending.
  assign pending_d = (pending_q & ~done_mask) | set_mask;

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue, mul_done})
      2'b10:   if (inflight_q != CNT_MAX) inflight_d = inflight_q + CNT_W'(1);
      2'b01:   if (inflight_q != '0)      inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // NOTE: the pending vector is a flat register of flops, not a RAM, so it
  // is cleared by the async reset like any other state; a reset abandons
  // every outstanding entry at once.
  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      inflight_q <= '0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
    end
  end

  assign full     = (inflight_q == CNT_MAX);
  assign inflight = inflight_q;

endmodule

// File: rtl/hazard_sb.sv
// hazard_sb: hazard unit for the brisc 5-stage pipeline with a register
// scoreboard for variable-latency MUL ops.
//   clk, rst_n                    clock, asynchronous active-low reset
//   rs1_d, rs2_d, rd_d            D-stage register indices
//   reg_write_d, long_lat_d       D writes rd / D is a MUL-class op
//   rs1_a, rs2_a, rd_a            A-stage register indices
//   reg_write_a, result_src_a     A writes rd / FROM_CACHE marks a load
//   rd_c, reg_write_c             C-stage destination and write enable
//   rd_wb, reg_write_wb           WB-stage destination and write enable
//   pc_src                        FROM_A means taken redirect
//   icache_mem_req, dcache_mem_req  cache miss in progress
//   mul_done, mul_done_rd         MUL writeback this cycle and its target
//   fwd_src1, fwd_src2            A-stage operand source
//   stall_f/d/a/c                 stage hold
//   flush_d/a/wb                  stage bubble
//   inflight                      outstanding long-latency op count
// Optional (HAZARD_PERF_CNT_EN): perf_load_stall, perf_sb_stall, perf_flush
// 32-bit saturating event counters.
module hazard_sb
  import brisc_pkg::*;
#(
  parameter int MAX_INFLIGHT = MAX_INFLIGHT_DEFAULT,
  parameter int NUM_REGS     = 2**REG_BITS
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [REG_BITS-1:0]               rs1_d,
  input  logic [REG_BITS-1:0]               rs2_d,
  input  logic [REG_BITS-1:0]               rd_d,
  input  logic                              reg_write_d,
  input  logic                              long_lat_d,
  input  logic [REG_BITS-1:0]               rs1_a,
  input  logic [REG_BITS-1:0]               rs2_a,
  input  logic [REG_BITS-1:0]               rd_a,
  input  logic                              reg_write_a,
  input  result_src_e                       result_src_a,
  input  logic [REG_BITS-1:0]               rd_c,
  input  logic [REG_BITS-1:0]               rd_wb,
  input  logic                              reg_write_c,
  input  logic                              reg_write_wb,
  input  pc_src_e                           pc_src,
  input  logic                              icache_mem_req,
  input  logic                              dcache_mem_req,
  input  logic                              mul_done,
  input  logic [REG_BITS-1:0]               mul_done_rd,
  output fwd_src_e                          fwd_src1,
  output fwd_src_e                          fwd_src2,
  output logic                              stall_f,
  output logic                              stall_d,
  output logic                              stall_a,
  output logic                              stall_c,
  output logic                              flush_d,
  output logic                              flush_a,
  output logic                              flush_wb,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]                       perf_load_stall,
  output logic [31:0]                       perf_sb_stall,
  output logic [31:0]                       perf_flush
`endif
);

  logic pend_rs1, pend_rs2, pend_rd, sb_full;
  logic load_stall, sb_stall, d_stall, redirect;
  logic stall_d_int, flush_a_int, flush_d_int, issue;

  hazard_scoreboard #(
    .MAX_INFLIGHT(MAX_INFLIGHT),
    .NUM_REGS    (NUM_REGS)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue      (issue),
    .issue_rd   (rd_d),
    .mul_done   (mul_done),
    .mul_done_rd(mul_done_rd),
    .rs1        (rs1_d),
    .rs2        (rs2_d),
    .rd         (rd_d),
    .pend_rs1   (pend_rs1),
    .pend_rs2   (pend_rs2),
    .pend_rd    (pend_rd),
    .full       (sb_full),
    .inflight   (inflight)
  );

  // Load-use: a non-x0 load in A feeding either D source.
  assign load_stall = (result_src_a == FROM_CACHE) && reg_write_a && (rd_a != '0) &&
                      ((rs1_d == rd_a) || (rs2_d == rd_a));

  // RAW and WAW against owed MUL results, plus the structural cap; a
  // same-cycle writeback frees a slot so a full counter does not block.
  assign sb_stall = ((rs1_d != '0) && pend_rs1) ||
                    ((rs2_d != '0) && pend_rs2) ||
                    (reg_write_d && (rd_d != '0) && pend_rd) ||
                    (long_lat_d && sb_full && !mul_done);

  assign d_stall     = load_stall | sb_stall;
  assign redirect    = (pc_src == FROM_A);
  assign stall_d_int = d_stall | dcache_mem_req;
  assign flush_a_int = (d_stall | redirect) & ~dcache_mem_req;
  assign flush_d_int = (redirect | icache_mem_req) & ~dcache_mem_req;

  assign issue = ~stall_d_int & ~flush_a_int & long_lat_d & reg_write_d & (rd_d != '0);

  // Outputs are forced quiet while reset is held so the pipeline sees no
  // spurious stalls, bubbles or forwards.
  assign stall_f  = rst_n & (d_stall | dcache_mem_req | icache_mem_req);
  assign stall_d  = rst_n & stall_d_int;
  assign stall_a  = rst_n & dcache_mem_req;
  assign stall_c  = rst_n & dcache_mem_req;
  assign flush_d  = rst_n & flush_d_int;
  assign flush_a  = rst_n & flush_a_int;
  assign flush_wb = rst_n & dcache_mem_req;
  assign fwd_src1 = rst_n ? fwd_select(rs1_a, rd_c, reg_write_c, rd_wb, reg_write_wb) : NONE;
  assign fwd_src2 = rst_n ? fwd_select(rs2_a, rd_c, reg_write_c, rd_wb, reg_write_wb) : NONE;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_load_stall <= '0;
      perf_sb_stall   <= '0;
      perf_flush      <= '0;
    end else begin
      if (load_stall && perf_load_stall != '1)             perf_load_stall <= perf_load_stall + 32'd1;
      if (sb_stall && !load_stall && perf_sb_stall != '1) perf_sb_stall   <= perf_sb_stall + 32'd1;
      if (flush_d_int && perf_flush != '1)                 perf_flush      <= perf_flush + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_sb.sv
module tb_hazard_sb;
  import brisc_pkg::*;

  logic                clk, rst_n;
  logic [REG_BITS-1:0] rs1_d, rs2_d, rd_d, rs1_a, rs2_a, rd_a, rd_c, rd_wb, mul_done_rd;
  logic                reg_write_d, long_lat_d, reg_write_a, reg_write_c, reg_write_wb;
  logic                icache_mem_req, dcache_mem_req, mul_done;
  result_src_e         result_src_a;
  pc_src_e             pc_src;
  fwd_src_e            fwd_src1, fwd_src2;
  logic                stall_f, stall_d, stall_a, stall_c, flush_d, flush_a, flush_wb;
  inflight_t           inflight;

  int checks = 0;
  int errors = 0;

  hazard_sb #(.MAX_INFLIGHT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .reg_write_d(reg_write_d), .long_lat_d(long_lat_d),
    .rs1_a(rs1_a), .rs2_a(rs2_a), .rd_a(rd_a),
    .reg_write_a(reg_write_a), .result_src_a(result_src_a),
    .rd_c(rd_c), .rd_wb(rd_wb), .reg_write_c(reg_write_c), .reg_write_wb(reg_write_wb),
    .pc_src(pc_src), .icache_mem_req(icache_mem_req), .dcache_mem_req(dcache_mem_req),
    .mul_done(mul_done), .mul_done_rd(mul_done_rd),
    .fwd_src1(fwd_src1), .fwd_src2(fwd_src2),
    .stall_f(stall_f), .stall_d(stall_d), .stall_a(stall_a), .stall_c(stall_c),
    .flush_d(flush_d), .flush_a(flush_a), .flush_wb(flush_wb),
    .inflight(inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A MUL writeback with nothing outstanding would mean the bench drove an
  // impossible sequence.
  always @(negedge clk) begin
    if (rst_n && mul_done && inflight == '0) begin
      errors++;
      $display("FAIL mul_done_with_zero_inflight: observed %0d expected nonzero", inflight);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input int rs1, input int rs2, input int rd, input logic rw, input logic ll);
    rs1_d = REG_BITS'(rs1); rs2_d = REG_BITS'(rs2); rd_d = REG_BITS'(rd);
    reg_write_d = rw; long_lat_d = ll;
  endtask

  task automatic idle();
    set_d(0, 0, 0, 1'b0, 1'b0);
    rs1_a = '0; rs2_a = '0; rd_a = '0; reg_write_a = 1'b0; result_src_a = FROM_ALU;
    rd_c = '0; rd_wb = '0; reg_write_c = 1'b0; reg_write_wb = 1'b0;
    pc_src = FROM_PC4; icache_mem_req = 1'b0; dcache_mem_req = 1'b0;
    mul_done = 1'b0; mul_done_rd = '0;
  endtask

  initial begin
    // Reset held with busy inputs: everything quiet.
    rst_n = 1'b0;
    idle();
    pc_src = FROM_A; dcache_mem_req = 1'b1; icache_mem_req = 1'b1;
    rs1_a = 5'd3; rd_c = 5'd3; reg_write_c = 1'b1;
    #2;
    check("rst_stall_f", 32'(stall_f), 0);
    check("rst_stall_a", 32'(stall_a), 0);
    check("rst_flush_d", 32'(flush_d), 0);
    check("rst_flush_wb", 32'(flush_wb), 0);
    check("rst_fwd1", 32'(fwd_src1), 32'(NONE));
    check("rst_inflight", 32'(inflight), 0);
    idle();
    #1 rst_n = 1'b1;
    tick();

    // MUL x5 issues, then dependent add stalls until writeback.
    set_d(1, 2, 5, 1'b1, 1'b1);
    #1 check("mul5_no_stall", 32'(stall_d), 0);
    tick();
    check("mul5_inflight", 32'(inflight), 1);
    set_d(5, 1, 6, 1'b1, 1'b0);
    #1;
    check("raw_stall_d", 32'(stall_d), 1);
    check("raw_stall_f", 32'(stall_f), 1);
    check("raw_flush_a", 32'(flush_a), 1);
    tick();
    check("raw_hold_stall_d", 32'(stall_d), 1);
    mul_done = 1'b1; mul_done_rd = 5'd5;
    #1;
    check("raw_done_stall_d", 32'(stall_d), 0);
    check("raw_done_flush_a", 32'(flush_a), 0);
    tick();
    mul_done = 1'b0;
    check("raw_done_inflight", 32'(inflight), 0);
    #1 check("raw_after_stall_d", 32'(stall_d), 0);
    tick();

    // Fill to MAX_INFLIGHT, then a fifth MUL hits the structural limit.
    for (int i = 1; i <= 4; i++) begin
      set_d(0, 0, i, 1'b1, 1'b1);
      #1 check("fill_no_stall", 32'(stall_d), 0);
      tick();
    end
    check("fill_inflight", 32'(inflight), 4);
    set_d(0, 0, 5, 1'b1, 1'b1);
    #1;
    check("full_stall_d", 32'(stall_d), 1);
    check("full_flush_a", 32'(flush_a), 1);
    mul_done = 1'b1; mul_done_rd = 5'd1;
    #1 check("full_done_stall_d", 32'(stall_d), 0);
    tick();
    mul_done = 1'b0;
    check("full_done_inflight", 32'(inflight), 4);
    set_d(1, 0, 10, 1'b1, 1'b0);
    #1 check("x1_cleared", 32'(stall_d), 0);
    set_d(0, 5, 10, 1'b1, 1'b0);
    #1 check("x5_pending", 32'(stall_d), 1);
    // Reissue to x2 in the cycle x2 is written back: set wins.
    set_d(0, 0, 2, 1'b1, 1'b1);
    mul_done = 1'b1; mul_done_rd = 5'd2;
    #1 check("waw_resolved_stall_d", 32'(stall_d), 0);
    tick();
    mul_done = 1'b0;
    check("reissue_inflight", 32'(inflight), 4);
    set_d(2, 0, 10, 1'b1, 1'b0);
    #1 check("x2_still_pending", 32'(stall_d), 1);
    set_d(0, 0, 0, 1'b0, 1'b0);
    for (int r = 2; r <= 5; r++) begin
      mul_done = 1'b1; mul_done_rd = REG_BITS'(r);
      tick();
    end
    mul_done = 1'b0;
    check("drain_inflight", 32'(inflight), 0);

    // Load-use.
    rd_a = 5'd7; reg_write_a = 1'b1; result_src_a = FROM_CACHE;
    set_d(7, 0, 8, 1'b1, 1'b0);
    #1;
    check("lu_stall_f", 32'(stall_f), 1);
    check("lu_stall_d", 32'(stall_d), 1);
    check("lu_flush_a", 32'(flush_a), 1);
    check("lu_stall_a", 32'(stall_a), 0);
    rd_a = 5'd0;
    #1 check("lu_x0_stall_d", 32'(stall_d), 0);
    rd_a = 5'd7; reg_write_a = 1'b0;
    #1 check("lu_nowrite_stall_d", 32'(stall_d), 0);
    rd_a = 5'd7; reg_write_a = 1'b1; result_src_a = FROM_ALU;
    #1 check("lu_alu_stall_d", 32'(stall_d), 0);
    idle();

    // Forwarding priority.
    rs1_a = 5'd3; rd_c = 5'd3; rd_wb = 5'd3; reg_write_c = 1'b1; reg_write_wb = 1'b1;
    #1 check("fwd1_c", 32'(fwd_src1), 32'(FROM_C));
    reg_write_c = 1'b0;
    #1 check("fwd1_wb", 32'(fwd_src1), 32'(FROM_WB));
    rs1_a = 5'd0;
    #1 check("fwd1_x0", 32'(fwd_src1), 32'(NONE));
    rs2_a = 5'd4; rd_c = 5'd3;  rd_wb = 5'd4; reg_write_c = 1'b1;
    #1 check("fwd2_wb", 32'(fwd_src2), 32'(FROM_WB));
    idle();
    tick();

    // Redirect while D holds MUL x9: flushed, never issued.
    set_d(0, 0, 9, 1'b1, 1'b1);
    pc_src = FROM_A;
    #1;
    check("br_flush_d", 32'(flush_d), 1);
    check("br_flush_a", 32'(flush_a), 1);
    check("br_stall_d", 32'(stall_d), 0);
    dcache_mem_req = 1'b1;
    #1;
    check("br_dc_flush_d", 32'(flush_d), 0);
    check("br_dc_flush_a", 32'(flush_a), 0);
    check("br_dc_stall_a", 32'(stall_a), 1);
    check("br_dc_stall_c", 32'(stall_c), 1);
    check("br_dc_flush_wb", 32'(flush_wb), 1);
    dcache_mem_req = 1'b0;
    tick();
    check("br_inflight", 32'(inflight), 0);
    pc_src = FROM_PC4;
    set_d(9, 0, 10, 1'b1, 1'b0);
    #1 check("br_x9_not_pending", 32'(stall_d), 0);
    set_d(0, 0, 0, 1'b0, 1'b0);
    icache_mem_req = 1'b1;
    #1;
    check("ic_flush_d", 32'(flush_d), 1);
    check("ic_stall_f", 32'(stall_f), 1);
    check("ic_stall_d", 32'(stall_d), 0);
    idle();
    tick();

    // Reset mid-operation.
    set_d(0, 0, 5, 1'b1, 1'b1);
    tick();
    set_d(0, 0, 3, 1'b1, 1'b1);
    tick();
    check("pre_rst_inflight", 32'(inflight), 2);
    set_d(5, 0, 6, 1'b1, 1'b0);
    #1 check("pre_rst_stall_d", 32'(stall_d), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_inflight", 32'(inflight), 0);
    check("mid_rst_stall_d", 32'(stall_d), 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_stall_d", 32'(stall_d), 0);
    check("post_rst_flush_a", 32'(flush_a), 0);
    tick();
    check("post_rst_inflight", 32'(inflight), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
